xbar_wr_order_ctrl: RTL and testbench

XBAR_WR_ORDER_CTRL -- requirements
Module: xbar_wr_order_ctrl

---
 rtl/xbar_pkg.sv | 23 ++
 rtl/xbar_sync_fifo.sv | 58 +++++
 rtl/xbar_wr_order_ctrl.sv | 134 +++++++++++++
 tb/tb_xbar_wr_order_ctrl.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/xbar_pkg.sv
// Shared definitions for the crossbar write-path blocks: width helpers and the
// write-order queue entry.
package xbar_pkg;

    // The entry is sized for the widest supported configuration.
    // Blocks pack only the low MW / LEN_WIDTH bits of each field.
    localparam int ENTRY_MW_MAX  = 8;
    localparam int ENTRY_LEN_MAX = 16;

    typedef struct packed {
        logic [ENTRY_MW_MAX-1:0]  master;
        logic [ENTRY_LEN_MAX-1:0] len;
    } order_entry_t;

    function automatic int mw_of(input int masters);
        return (masters > 1) ? $clog2(masters) : 1;
    endfunction

    function automatic int ow_of(input int max_outstanding);
        return $clog2(max_outstanding + 1);
    endfunction

endpackage

// File: rtl/xbar_sync_fifo.sv
// Single-clock FIFO with registered head; the extra pointer bit separates
// full from empty. Shared by the crossbar channel queues.
module xbar_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] front
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];

    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign front = mem_q[rd_ptr_q[AW-1:0]];

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push && !full) begin
            mem_d[wr_ptr_q[AW-1:0]] = din;
            wr_ptr_d = wr_ptr_q + PW'(1);
        end
        if (pop && !empty) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage needs no reset: reads are qualified by the pointers.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

endmodule

// File: rtl/xbar_wr_order_ctrl.sv
// Write-order controller: records AW grant order, routes W beats from the
// queue head by beat count, and tracks writes outstanding until B return.
module xbar_wr_order_ctrl
    import xbar_pkg::*;
#(
    parameter  int MASTERS         = 2,
    parameter  int LEN_WIDTH       = 4,
    parameter  int ORDER_DEPTH     = 4,
    parameter  int MAX_OUTSTANDING = 8,
    localparam int MW              = mw_of(MASTERS),
    localparam int OW              = ow_of(MAX_OUTSTANDING)
) (
    input  logic                 ACLK,
    input  logic                 ARESETn,
    input  logic                 aw_req_valid,
    input  logic [MW-1:0]        aw_req_master,
    input  logic [LEN_WIDTH-1:0] aw_req_len,
    output logic                 aw_req_ready,
    input  logic                 w_in_valid,
    input  logic                 w_in_last,
    input  logic                 w_down_full,
    output logic                 w_in_ready,
    output logic [MW-1:0]        w_src_master,
    output logic                 w_src_valid,
    input  logic                 b_fire,
    output logic [OW-1:0]        outstanding,
    output logic                 err_wlast,
    output logic                 err_b_underflow
);

    localparam int EW = MW + LEN_WIDTH;

    logic                 fifo_full, fifo_empty;
    logic [EW-1:0]        fifo_front;
    order_entry_t         head;
    logic                 unused_head;
    logic [MW-1:0]        head_master;
    logic [LEN_WIDTH-1:0] head_len;

    logic                 aw_en_q, aw_en_d;
    logic [OW-1:0]        out_q, out_d;
    logic [LEN_WIDTH:0]   beat_q, beat_d;
    logic                 err_wlast_q, err_wlast_d;
    logic                 err_uf_q, err_uf_d;

    logic                 aw_fire, w_fire, beat_last, pop;

    xbar_sync_fifo #(
        .WIDTH (EW),
        .DEPTH (ORDER_DEPTH)
    ) u_order_q (
        .clk   (ACLK),
        .rst_n (ARESETn),
        .push  (aw_fire),
        .pop   (pop),
        .din   ({aw_req_master, aw_req_len}),
        .full  (fifo_full),
        .empty (fifo_empty),
        .front (fifo_front)
    );

    always_comb begin
        head = '0;
        head.master[MW-1:0]       = fifo_front[EW-1:LEN_WIDTH];
        head.len[LEN_WIDTH-1:0]   = fifo_front[LEN_WIDTH-1:0];
    end

    assign head_master = head.master[MW-1:0];
    assign head_len    = head.len[LEN_WIDTH-1:0];
    assign unused_head = ^head;

    // aw_en_q holds AW off during reset and opens it one edge after release.
    assign aw_req_ready = aw_en_q && !fifo_full &&
                          (out_q < OW'(MAX_OUTSTANDING));
    assign aw_fire      = aw_req_valid && aw_req_ready;

    assign w_src_valid  = !fifo_empty;
    assign w_src_master = fifo_empty ? '0 : head_master;
    assign w_in_ready   = !fifo_empty && !w_down_full;
    assign w_fire       = w_in_valid && w_in_ready;

    // The burst boundary comes from the AWLEN count; WLAST is only cross-checked.
    assign beat_last = (beat_q == {1'b0, head_len});
    assign pop       = w_fire && beat_last;

    always_comb begin
        aw_en_d     = 1'b1;
        beat_d      = beat_q;
        err_wlast_d = err_wlast_q;
        if (w_fire) begin
            beat_d = beat_last ? '0 : beat_q + (LEN_WIDTH+1)'(1);
            if (w_in_last != beat_last) begin
                err_wlast_d = 1'b1;
            end
        end
    end

    always_comb begin
        out_d    = out_q;
        err_uf_d = err_uf_q;
        unique case ({aw_fire, b_fire})
            2'b10: out_d = out_q + OW'(1);
            2'b01: begin
                if (out_q != '0) begin
                    out_d = out_q - OW'(1);
                end else begin
                    err_uf_d = 1'b1;
                end
            end
            default: out_d = out_q;
        endcase
    end

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            aw_en_q     <= 1'b0;
            out_q       <= '0;
            beat_q      <= '0;
            err_wlast_q <= 1'b0;
            err_uf_q    <= 1'b0;
        end else begin
            aw_en_q     <= aw_en_d;
            out_q       <= out_d;
            beat_q      <= beat_d;
            err_wlast_q <= err_wlast_d;
            err_uf_q    <= err_uf_d;
        end
    end

    assign outstanding     = out_q;
    assign err_wlast       = err_wlast_q;
    assign err_b_underflow = err_uf_q;

endmodule

// File: tb/tb_xbar_wr_order_ctrl.sv
// Directed bench for xbar_wr_order_ctrl: beat-level scoreboard of expected
// routing plus small occupancy/outstanding models; two instances cover depth and limit.
module tb_xbar_wr_order_ctrl;

    logic       ACLK = 1'b0;
    logic       ARESETn;
    logic       aw_req_valid;
    logic [0:0] aw_req_master;
    logic [3:0] aw_req_len;
    logic       w_in_valid, w_in_last, w_down_full, b_fire;

    logic       d1_awr, d1_wr, d1_wsv, d1_ewl, d1_euf;
    logic [0:0] d1_wsm;
    logic [3:0] d1_out;
    logic       d2_awr, d2_wr, d2_wsv, d2_ewl, d2_euf;
    logic [0:0] d2_wsm;
    logic [1:0] d2_out;

    logic       sel;
    logic       s_awr, s_wr, s_wsv, s_ewl, s_euf;
    logic [0:0] s_wsm;
    logic [3:0] s_out;

    typedef struct {
        int master;
        bit last;
    } beat_t;

    beat_t sb[$];
    int    n_tests = 0;
    int    n_fail  = 0;
    int    occ, exp_out;
    bit    exp_uf, exp_wl;

    always #5 ACLK = ~ACLK;

    xbar_wr_order_ctrl u_dut (
        .ACLK (ACLK), .ARESETn (ARESETn),
        .aw_req_valid (aw_req_valid), .aw_req_master (aw_req_master),
        .aw_req_len (aw_req_len), .aw_req_ready (d1_awr),
        .w_in_valid (w_in_valid), .w_in_last (w_in_last),
        .w_down_full (w_down_full), .w_in_ready (d1_wr),
        .w_src_master (d1_wsm), .w_src_valid (d1_wsv),
        .b_fire (b_fire), .outstanding (d1_out),
        .err_wlast (d1_ewl), .err_b_underflow (d1_euf)
    );

    xbar_wr_order_ctrl #(.MAX_OUTSTANDING(2)) u_dut_lim (
        .ACLK (ACLK), .ARESETn (ARESETn),
        .aw_req_valid (aw_req_valid), .aw_req_master (aw_req_master),
        .aw_req_len (aw_req_len), .aw_req_ready (d2_awr),
        .w_in_valid (w_in_valid), .w_in_last (w_in_last),
        .w_down_full (w_down_full), .w_in_ready (d2_wr),
        .w_src_master (d2_wsm), .w_src_valid (d2_wsv),
        .b_fire (b_fire), .outstanding (d2_out),
        .err_wlast (d2_ewl), .err_b_underflow (d2_euf)
    );

    assign s_awr = sel ? d2_awr : d1_awr;
    assign s_wr  = sel ? d2_wr  : d1_wr;
    assign s_wsv = sel ? d2_wsv : d1_wsv;
    assign s_wsm = sel ? d2_wsm : d1_wsm;
    assign s_ewl = sel ? d2_ewl : d1_ewl;
    assign s_euf = sel ? d2_euf : d1_euf;
    assign s_out = sel ? {2'b00, d2_out} : d1_out;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $display("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
            $error("check %s", tag);
        end
    endtask

    task automatic do_reset();
        ARESETn       = 1'b0;
        aw_req_valid  = 1'b0;
        aw_req_master = '0;
        aw_req_len    = '0;
        w_in_valid    = 1'b0;
        w_in_last     = 1'b0;
        b_fire        = 1'b0;
        sb.delete();
        occ = 0; exp_out = 0; exp_uf = 1'b0; exp_wl = 1'b0;
        repeat (2) @(posedge ACLK);
        #2 ARESETn = 1'b1;
        @(posedge ACLK); #2;
        chk("ready_after_reset", s_awr, 1);
    endtask

    // One clock of stimulus: optional AW, optional W beat (inv flips WLAST), optional B.
    task automatic cyc(input bit awv, input int m, input int len,
                       input bit wv, input bit inv, input bit bf);
        bit    exp_awr, aw_acc, w_acc;
        int    maxo;
        beat_t e;
        maxo          = sel ? 2 : 8;
        aw_req_valid  = awv;
        aw_req_master = m[0:0];
        aw_req_len    = len[3:0];
        w_in_valid    = wv;
        w_in_last     = (sb.size() > 0) ? (sb[0].last ^ inv) : 1'b0;
        b_fire        = bf;
        #1;
        exp_awr = (occ < 4) && (exp_out < maxo);
        chk("aw_req_ready", s_awr, exp_awr);
        chk("w_in_ready", s_wr, (sb.size() > 0) && !w_down_full);
        chk("w_src_valid_pre", s_wsv, sb.size() > 0);
        aw_acc = awv && exp_awr;
        w_acc  = wv && (sb.size() > 0) && !w_down_full;
        if (w_acc) begin
            chk("w_src_master", s_wsm, sb[0].master);
            e = sb.pop_front();
            if (e.last) occ--;
            if (inv) exp_wl = 1'b1;
        end
        if (aw_acc) begin
            for (int i = 0; i <= len; i++) sb.push_back('{master: m, last: (i == len)});
            occ++;
        end
        if (aw_acc && !bf) exp_out++;
        else if (bf && !aw_acc) begin
            if (exp_out > 0) exp_out--;
            else exp_uf = 1'b1;
        end
        @(posedge ACLK); #2;
        aw_req_valid = 1'b0;
        w_in_valid   = 1'b0;
        w_in_last    = 1'b0;
        b_fire       = 1'b0;
        chk("outstanding", s_out, exp_out);
        chk("err_b_underflow", s_euf, exp_uf);
        chk("err_wlast", s_ewl, exp_wl);
        chk("w_src_valid", s_wsv, sb.size() > 0);
        if (sb.size() > 0) chk("w_src_master_head", s_wsm, sb[0].master);
    endtask

    initial begin
        int exp_seq[6];
        exp_seq = '{0, 1, 1, 0, 0, 0};
        sel = 1'b0; w_down_full = 1'b0; ARESETn = 1'b0;
        aw_req_valid = 1'b0; aw_req_master = '0; aw_req_len = '0;
        w_in_valid = 1'b0; w_in_last = 1'b0; b_fire = 1'b0;
        #3;
        chk("rst_w_src_valid", s_wsv, 0);
        chk("rst_w_src_master", s_wsm, 0);
        chk("rst_w_in_ready", s_wr, 0);
        chk("rst_aw_req_ready", s_awr, 0);
        chk("rst_outstanding", s_out, 0);
        do_reset();

        // Single 4-beat burst from master 1, one stall on downstream full.
        cyc(1, 1, 3, 0, 0, 0);
        w_down_full = 1'b1;
        cyc(0, 0, 0, 1, 0, 0);
        w_down_full = 1'b0;
        repeat (4) cyc(0, 0, 0, 1, 0, 0);
        chk("a_src_valid", s_wsv, 0);
        chk("a_err_wlast", s_ewl, 0);
        chk("a_outstanding", s_out, 1);
        cyc(0, 0, 0, 0, 0, 1);

        // Three back-to-back AWs, routing follows grant order.
        cyc(1, 0, 0, 0, 0, 0);
        cyc(1, 1, 1, 0, 0, 0);
        cyc(1, 0, 2, 0, 0, 0);
        chk("b_outstanding", s_out, 3);
        for (int i = 0; i < 6; i++) begin
            chk("b_master_seq", s_wsm, exp_seq[i]);
            cyc(0, 0, 0, 1, 0, 0);
        end
        chk("b_drained", s_wsv, 0);

        // Order queue full, then push and pop in the same cycle.
        do_reset();
        for (int i = 0; i < 4; i++) cyc(1, i % 2, 0, 0, 0, 0);
        chk("c_full_ready", s_awr, 0);
        cyc(1, 1, 0, 1, 0, 0);
        chk("c_ready_after_pop", s_awr, 1);
        cyc(1, 1, 0, 1, 0, 0);
        chk("c_push_pop_ready", s_awr, 1);
        cyc(1, 0, 0, 0, 0, 0);
        chk("c_full_again", s_awr, 0);
        repeat (4) cyc(0, 0, 0, 1, 0, 0);
        chk("c_drained", s_wsv, 0);

        // Early WLAST on a 2-beat burst.
        do_reset();
        cyc(1, 1, 1, 0, 0, 0);
        cyc(0, 0, 0, 1, 1, 0);
        chk("e_err_wlast", s_ewl, 1);
        chk("e_not_popped", s_wsv, 1);
        cyc(0, 0, 0, 1, 0, 0);
        chk("e_popped", s_wsv, 0);

        // Outstanding limit of 2 on the second instance.
        sel = 1'b1;
        do_reset();
        cyc(1, 0, 0, 0, 0, 0);
        cyc(1, 1, 0, 0, 0, 0);
        repeat (2) cyc(0, 0, 0, 1, 0, 0);
        chk("d_ready_at_max", s_awr, 0);
        chk("d_out_max", s_out, 2);
        cyc(1, 0, 0, 0, 0, 1);
        chk("d_ready_after_b", s_awr, 1);
        cyc(1, 0, 0, 0, 0, 1);
        chk("d_out_aw_and_b", s_out, 1);
        cyc(1, 1, 0, 0, 0, 0);
        chk("d_ready_max_again", s_awr, 0);
        sel = 1'b0;

        // B underflow, then asynchronous reset in the middle of a burst.
        do_reset();
        cyc(0, 0, 0, 0, 0, 1);
        chk("f_underflow", s_euf, 1);
        chk("f_out_zero", s_out, 0);
        cyc(1, 1, 3, 0, 0, 0);
        cyc(0, 0, 0, 1, 1, 0);
        cyc(0, 0, 0, 1, 0, 0);
        @(negedge ACLK);
        ARESETn = 1'b0;
        #1;
        chk("f_rst_w_src_valid", s_wsv, 0);
        chk("f_rst_w_src_master", s_wsm, 0);
        chk("f_rst_w_in_ready", s_wr, 0);
        chk("f_rst_aw_req_ready", s_awr, 0);
        chk("f_rst_outstanding", s_out, 0);
        chk("f_rst_err_wlast", s_ewl, 0);
        chk("f_rst_err_b_underflow", s_euf, 0);
        do_reset();
        chk("f_queue_discarded", s_wsv, 0);
        cyc(1, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 1, 0, 0);
        chk("f_count_cleared", s_wsv, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
